mul_iter_param: RTL

MUL_ITER_PARAM -- requirements
Module: mul_iter_param

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_pp_step.sv | 24 ++
 rtl/mul_iter_param.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: RISC-V M opcode encoding and FSM states.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_pp_step.sv
// One shift-add step: adds (multiplicand x BPC multiplier bits) << (step*BPC) into the accumulator.
module mul_pp_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic [2*XLEN-1:0]            acc_i,
  input  logic [XLEN-1:0]              mcand_i,
  input  logic [BPC-1:0]               bits_i,
  input  logic [$clog2(XLEN/BPC):0]    step_i,
  output logic [2*XLEN-1:0]            acc_o
);

  localparam int SW = $clog2(XLEN/BPC) + 1;

  logic [2*XLEN-1:0] pp;
  logic [31:0]       shamt;

  always_comb begin
    pp    = {{XLEN{1'b0}}, mcand_i} * {{(2*XLEN-BPC){1'b0}}, bits_i};
    shamt = {{(32-SW){1'b0}}, step_i} * 32'(BPC);
    acc_o = acc_i + (pp << shamt);
  end

endmodule

// File: rtl/mul_iter_param.sv
// Iterative RISC-V M multiplier (MUL/MULH/MULHSU/MULHU): sign-magnitude operands,
// BPC multiplier bits retired per cycle, signed fix-up and half select on entering DONE.
module mul_iter_param
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mul_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_multiply
);

  localparam int NSTEP = XLEN / BPC;
  localparam int SW    = $clog2(NSTEP) + 1;

  generate
    if (!((XLEN == 8 || XLEN == 16 || XLEN == 32 || XLEN == 64) &&
          (BPC == 1 || BPC == 2 || BPC == 4) && (XLEN % BPC == 0))) begin : g_bad_params
      $error("mul_iter_param: illegal XLEN/BPC combination");
    end
  endgenerate

  // Handshake: a request transfers on a rising edge where start=1, ready=1 and flush=0;
  // operands are sampled only then. done is a single-cycle valid for result_multiply.

  mul_state_e        state_q, state_d;
  mul_op_e           op_q, op_d, op_in;
  logic [XLEN-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, product;
  logic [SW-1:0]     step_q, step_d;
  logic              rs1_signed, rs2_signed, s1, s2;
  logic [XLEN-1:0]   mag1, mag2, res_sel;

  mul_pp_step #(.XLEN(XLEN), .BPC(BPC)) u_pp_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BPC-1:0]),
    .step_i  (step_q),
    .acc_o   (acc_step)
  );

  always_comb begin
    op_in      = mul_op_e'(mul_opcode);
    rs1_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    rs2_signed = (op_in == OP_MULH);
    s1         = rs1_signed & operand1[XLEN-1];
    s2         = rs2_signed & operand2[XLEN-1];
    // Negating the most-negative value wraps to itself, which is its correct unsigned magnitude.
    mag1       = s1 ? -operand1 : operand1;
    mag2       = s2 ? -operand2 : operand2;
    product    = neg_q ? -acc_q : acc_q;
    res_sel    = (op_q == OP_MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d  = ST_CALC;
          op_d     = op_in;
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = s1 ^ s2;
          acc_d    = '0;
          step_d   = '0;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (step_q == SW'(NSTEP)) begin
          // The accumulator now carries the signed product for the DONE cycle.
          state_d = ST_DONE;
          acc_d   = product;
        end else begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> BPC;
          step_d   = step_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush) result_d = res_sel;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  // A flush in the DONE cycle hides both the pulse and the new value.
  assign ready           = (state_q == ST_IDLE);
  assign busy            = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign done            = (state_q == ST_DONE) && !flush;
  assign result_multiply = done ? res_sel : result_q;

endmodule
